dram_responder: RTL and testbench
=================================

# dram_responder

Target-side model of the data-RAM DRAM port. It sits opposite the data-RAM initiator on the `valid_dram`/`rw_dram`/`addr_dram`/`din_dram` → `dout_dram`/`ready_dram` interface. It accepts one request at a time, services it from an internal word array after a programmable latency, and returns a single-cycle `ready_dram` pulse. It replaces the ad-hoc dummy memory in simulation and FPGA bring-up, with deterministic latency and out-of-range reporting.

## Interface
Parameters:
- `LATENCY`, 2: cycles from request acceptance to `ready_dram`; must be at least 2.
- `DEPTH_LOG2`, 17: log2 of the word count in the backing array.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_dram`  in  1  request valid; level, held by the initiator until it sees `ready_dram`.
- `rw_dram`  in  1  1 = write, 0 = read; sampled with `valid_dram`.
- `addr_dram`  in  27  halfword address; word index = `addr_dram[DEPTH_LOG2:1]`; bit 0 ignored.
- `din_dram`  in  32  write data.
- `dout_dram`  out  32  read data; valid in the `ready_dram` cycle and held until the next read completes.
- `ready_dram`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the cycle after acceptance through the `ready_dram` cycle.
- `addr_err`  out  1  pulses with `ready_dram` when the request was out of range.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE, `valid_dram`=1:
  - Capture `rw`, address, data and the range check into registers.
  - Load the counter with `LATENCY-2`.
  - Go to WAIT if the counter is nonzero, otherwise to ACCESS.
- WAIT: decrement the counter; go to ACCESS when it reaches 0. Inputs are ignored.
- ACCESS:
  - Drive the array enable with the captured index.
  - Write: write the array when in range.
  - Read: the array output is registered at the end of this cycle.
  - Next state is RESP.
- RESP:
  - `ready_dram`=1.
  - Read in range: `dout_dram` = array word.
  - Read out of range: `dout_dram` = 0 and `addr_err`=1.
  - Write: `dout_dram` unchanged. Out-of-range writes are dropped and `addr_err`=1.
  - `valid_dram` is ignored this cycle; the initiator still drives it high here.
  - Next state is IDLE.
- Out of range means `addr_dram[26:DEPTH_LOG2+1]` != 0.
- Back-to-back requests: a `valid_dram`=1 seen in the IDLE cycle right after RESP is a new request. No dead cycle is required beyond RESP.
- Input changes during WAIT, ACCESS or RESP have no effect; only the captured values are used.

## Timing
- Acceptance cycle is T0, the IDLE cycle sampling `valid_dram`=1.
- ACCESS is cycle T0+LATENCY-1; `ready_dram` is high in cycle T0+LATENCY only.
- Throughput is one request per LATENCY+1 cycles.
- Reset values: state=IDLE, `ready_dram`=0, `busy`=0, `addr_err`=0, `dout_dram`=0, counter=0.
- Array contents are not reset.
- Reset mid-operation: the request is aborted immediately and no `ready_dram` is produced.
  - A write aborted before ACCESS leaves the array unchanged.
  - A write aborted at ACCESS may or may not have committed; bench treats that word as undefined.
- `valid_dram` dropping before `ready_dram` (protocol violation): the request still completes with a normal `ready_dram` pulse.

## Structure
- Shared package `dram_pkg`:
  - State enum `dram_resp_state_t` (IDLE/WAIT/ACCESS/RESP).
  - `DRAM_ADDR_W`=27 and `DRAM_DATA_W`=32.
  - Constant `DRAM_RW_WRITE`=1'b1.
- Sub-module `dram_model_mem`:
  - Single-port, synchronous-read, write-first array.
  - Ports: `clk`, `en`, `we`, `addr[DEPTH_LOG2-1:0]`, `din`, `dout`.
  - Inferable as BRAM.
- FSM, counter, capture registers and range check stay in `dram_responder`.

## Test plan
- Reset: assert `rst` mid-simulation, asynchronously between edges. Required: `ready_dram`, `busy`, `addr_err` and `dout_dram` all go to 0 immediately.
- Write then read, LATENCY=2:
  - Write 0xDEADBEEF at `addr_dram`=0x0002000 → `ready_dram` in T0+2.
  - Read the same address → `ready_dram` in T0+2, `dout_dram`=0xDEADBEEF, `addr_err`=0.
- Back-to-back, LATENCY=5: write 0x11111111 to 0x10, write 0x22222222 to 0x12, read 0x10, read 0x12, with `valid_dram` held high continuously. Required:
  - `ready_dram` pulses exactly 6 cycles apart.
  - Reads return 0x11111111, then 0x22222222.
  - No extra requests are accepted during RESP.
- Out of range, DEPTH_LOG2=17:
  - Write 0xCAFEF00D to `addr_dram`=0x0040000 → `ready_dram`=1, `addr_err`=1.
  - Read of 0x0000000 afterwards is unchanged.
  - Read of 0x0040000 → `dout_dram`=0, `addr_err`=1.
- Reset mid-operation: assert `rst` in the WAIT of a write of 0x5A5A5A5A to 0x20, with LATENCY=5. Required:
  - No `ready_dram` pulse.
  - After release, a read of 0x20 returns the prior contents.
- Hold behaviour: a read returns 0x12345678, then a write completes. Required: `dout_dram` stays 0x12345678 through and after the write's `ready_dram`.

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the DRAM port responder
package dram_pkg;
  localparam int DRAM_ADDR_W = 27;
  localparam int DRAM_DATA_W = 32;
  localparam logic DRAM_RW_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dram_resp_state_t;
endpackage

// File: rtl/dram_model_mem.sv
// dram_model_mem: single-port synchronous-read write-first word array
module dram_model_mem
  import dram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 17
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  addr,
  input  logic [DRAM_DATA_W-1:0] din,
  output logic [DRAM_DATA_W-1:0] dout
);
  logic [DRAM_DATA_W-1:0] mem [2**DEPTH_LOG2];
  // array port: write-first so a write returns the new word on dout
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= we ? din : mem[addr];
    end
  end
endmodule

// File: rtl/dram_responder.sv
// dram_responder: target-side DRAM port model with fixed latency and range reporting
module dram_responder
  import dram_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_dram,
  input  logic                   rw_dram,
  input  logic [DRAM_ADDR_W-1:0] addr_dram,
  input  logic [DRAM_DATA_W-1:0] din_dram,
  output logic [DRAM_DATA_W-1:0] dout_dram,
  output logic                   ready_dram,
  output logic                   busy,
  output logic                   addr_err
);
  localparam int CW = 16;
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 2);
  dram_resp_state_t state, next;
  logic [CW-1:0] cnt;
  logic rw_q, oor_q, oor, en, we;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DRAM_DATA_W-1:0] din_q, dout_q, mem_dout;
  assign oor = (addr_dram >> (DEPTH_LOG2 + 1)) != '0;
  // state, countdown, request capture and held read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rw_q   <= 1'b0;
      oor_q  <= 1'b0;
      idx_q  <= '0;
      din_q  <= '0;
      dout_q <= '0;
    end else begin
      state <= next;
      if (state == IDLE && valid_dram) begin
        rw_q  <= rw_dram;
        oor_q <= oor;
        idx_q <= addr_dram[DEPTH_LOG2:1];
        din_q <= din_dram;
        cnt   <= LOAD;
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == RESP && rw_q != DRAM_RW_WRITE) dout_q <= dout_dram;
    end
  end
  // next state and outputs decoded from the current state
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = !valid_dram ? IDLE : (LOAD != '0 ? WAIT : ACCESS);
      WAIT:    next = cnt == CW'(1) ? ACCESS : WAIT;
      ACCESS:  next = RESP;
      default: next = IDLE;
    endcase
    ready_dram = state == RESP;
    busy       = state != IDLE;
    addr_err   = ready_dram && oor_q;
    en         = state == ACCESS;
    we         = rw_q == DRAM_RW_WRITE && !oor_q;
    dout_dram  = (ready_dram && rw_q != DRAM_RW_WRITE) ? (oor_q ? '0 : mem_dout) : dout_q;
  end
  dram_model_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk  (clk),
    .en   (en),
    .we   (we),
    .addr (idx_q),
    .din  (din_q),
    .dout (mem_dout)
  );
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: randomized scoreboard bench for dram_responder
module tb_dram_responder;
  import dram_pkg::*;
  localparam int L = 5;
  logic clk = 0, rst = 1;
  logic valid = 0, rw = 0;
  logic [26:0] addr = '0;
  logic [31:0] din = '0, dout;
  logic ready, busy, aerr;
  logic v2 = 0, rw2 = 0;
  logic [26:0] a2 = '0;
  logic [31:0] d2 = '0, o2;
  logic r2, b2, e2;
  dram_responder #(.LATENCY(L), .DEPTH_LOG2(17)) dut (
    .clk(clk), .rst(rst), .valid_dram(valid), .rw_dram(rw), .addr_dram(addr),
    .din_dram(din), .dout_dram(dout), .ready_dram(ready), .busy(busy), .addr_err(aerr));
  dram_responder #(.LATENCY(2), .DEPTH_LOG2(17)) dut2 (
    .clk(clk), .rst(rst), .valid_dram(v2), .rw_dram(rw2), .addr_dram(a2),
    .din_dram(d2), .dout_dram(o2), .ready_dram(r2), .busy(b2), .addr_err(e2));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  typedef struct {int cyc; bit err; bit dk; logic [31:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] mm [int];
  logic [31:0] last_rd = '0;
  bit last_k = 1;
  logic [26:0] pool [8];

  task automatic chk(string nm, bit ok, logic [31:0] act, logic [31:0] ex);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  task automatic push(bit w, logic [26:0] a, logic [31:0] d, int c);
    bit o = a[26:18] != 0;
    int i = int'(a[17:1]);
    exp_t x;
    x.cyc = c;
    x.err = o;
    if (w) begin
      if (!o) mm[i] = d;
      x.dk = last_k;
      x.d = last_rd;
    end else begin
      x.dk = o || mm.exists(i);
      x.d = (o || !mm.exists(i)) ? 32'h0 : mm[i];
      last_rd = x.d;
      last_k = x.dk;
    end
    q.push_back(x);
  endtask

  task automatic req(bit w, logic [26:0] a, logic [31:0] d, bit b2b, bit drop);
    int c = cyc;
    bit seen = 0;
    valid = 1; rw = w; addr = a; din = d;
    push(w, a, d, (b2b ? c + 1 : c) + L);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = ready;
      if (!seen && (!b2b || k >= 1)) begin
        rw = 1'($urandom); addr = 27'($urandom); din = $urandom;
        if (drop) valid = 0;
      end
    end
    if (!seen) chk("ready_timeout", 0, 32'(cyc), 32'(c + L));
  endtask

  task automatic idle();
    valid = 0; rw = 1'($urandom); addr = 27'($urandom); din = $urandom;
    @(negedge clk);
    chk("idle_busy", busy === 1'b0, 32'(busy), 0);
    chk("idle_ready", ready === 1'b0, 32'(ready), 0);
    if (last_k) chk("dout_hold", dout === last_rd, dout, last_rd);
  endtask

  // scoreboard monitor: every completion pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (q.size() == 0) chk("unexpected_ready", 0, 32'(cyc), 0);
      else begin
        e = q.pop_front();
        chk("ready_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
        chk("addr_err", aerr === e.err, 32'(aerr), 32'(e.err));
        chk("busy_at_ready", busy === 1'b1, 32'(busy), 1);
        if (e.dk) chk("dout", dout === e.d, dout, e.d);
      end
    end
  end

  initial begin
    int c;
    bit b;
    logic [26:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready === 1'b0, 32'(ready), 0);
    chk("rst_busy", busy === 1'b0, 32'(busy), 0);
    chk("rst_dout", dout === 32'h0, dout, 0);
    rst = 0;
    @(negedge clk);
    a2 = 27'h0002000; d2 = 32'hDEADBEEF; rw2 = 1; v2 = 1; c = cyc;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (r2) break; end
    chk("l2_write_latency", cyc - c == 2, 32'(cyc - c), 2);
    v2 = 0;
    @(negedge clk);
    rw2 = 0; v2 = 1; d2 = '0; c = cyc;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (r2) break; end
    chk("l2_read_latency", cyc - c == 2, 32'(cyc - c), 2);
    chk("l2_read_data", o2 === 32'hDEADBEEF, o2, 32'hDEADBEEF);
    chk("l2_addr_err", e2 === 1'b0, 32'(e2), 0);
    v2 = 0;
    req(1, 27'h0, 32'h0BADF00D, 0, 0); idle();
    req(1, 27'h20, 32'h600DCAFE, 0, 0); idle();
    req(1, 27'h10, 32'h11111111, 0, 0);
    req(1, 27'h12, 32'h22222222, 1, 0);
    req(0, 27'h10, 32'h0, 1, 0);
    req(0, 27'h12, 32'h0, 1, 0); idle();
    req(1, 27'h0040000, 32'hCAFEF00D, 0, 0); idle();
    req(0, 27'h0, 32'h0, 0, 0); idle();
    req(0, 27'h0040000, 32'h0, 0, 0); idle();
    req(1, 27'h30, 32'h12345678, 0, 0); idle();
    req(0, 27'h30, 32'h0, 0, 0); idle();
    req(1, 27'h32, 32'h00000009, 0, 0); idle(); idle();
    valid = 1; rw = 1; addr = 27'h20; din = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("amid_ready", ready === 1'b0, 32'(ready), 0);
    chk("amid_busy", busy === 1'b0, 32'(busy), 0);
    chk("amid_err", aerr === 1'b0, 32'(aerr), 0);
    chk("amid_dout", dout === 32'h0, dout, 0);
    last_rd = '0; last_k = 1; valid = 0;
    repeat (3) begin @(negedge clk); chk("rst_no_ready", ready === 1'b0, 32'(ready), 0); end
    rst = 0;
    repeat (L + 2) idle();
    req(0, 27'h20, 32'h0, 0, 0); idle();
    for (int i = 0; i < 8; i++) begin
      pool[i] = 27'(($urandom_range(0, 131071) << 1) | $urandom_range(0, 1));
      req(1, pool[i], $urandom, 0, 0); idle();
    end
    req(0, pool[0], 32'h0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      b = 1'($urandom);
      if (!b) idle();
      a = ($urandom_range(0, 4) == 0) ? {9'($urandom_range(1, 511)), 18'($urandom)}
                                      : pool[$urandom_range(0, 7)];
      req(1'($urandom), a, $urandom, b, !b && $urandom_range(0, 3) == 0);
    end
    idle(); idle();
    chk("queue_drained", q.size() == 0, 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
